armleocpu_operand_fetch: RTL and testbench

- Initiator side of the core register file. Accepts decoded instructions, issues rs1/rs2 reads to the register file, and tracks pending destination writes with a 32-entry scoreboard. Stalls on RAW/WAW hazards.
- Forwards same-cycle writeback data, holds operands coherent while the execute stage back-pressures, and owns the register file write port on behalf of writeback.
- Sits between decode and execute.

---
 rtl/armleocpu_operand_fetch_pkg.sv | 18 +
 rtl/armleocpu_operand_fetch_scoreboard.sv | 51 +++++
 rtl/armleocpu_operand_fetch.sv | 143 ++++++++++++++
 tb/tb_armleocpu_operand_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_operand_fetch_pkg.sv
// Shared widths and small helpers for the operand fetch stage.
// Register index width, XLEN and the writeback-match test used by every lane.
package armleocpu_operand_fetch_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    // x0 is hardwired, so a write to it never matches anything.
    function automatic logic wb_hits(input logic wb_valid, input reg_idx_t wb_addr,
                                     input reg_idx_t idx);
        return wb_valid && (wb_addr == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/armleocpu_operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Writeback and flush clear bits, issue sets them; a set beats a same-cycle clear.
module armleocpu_operand_fetch_scoreboard
    import armleocpu_operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wb_valid,
    input  reg_idx_t wb_rd_addr,
    input  logic     set_en,
    input  reg_idx_t set_addr,
    input  logic     kill_en,
    input  reg_idx_t kill_addr,
    input  reg_idx_t rs1_addr,
    input  reg_idx_t rs2_addr,
    input  reg_idx_t rd_addr,
    output logic     rs1_busy,
    output logic     rs2_busy,
    output logic     rd_busy
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] kill_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] busy_vec;

    always_comb begin
        clr_vec  = '0;
        kill_vec = '0;
        set_vec  = '0;
        if (wb_valid && wb_rd_addr != '0) clr_vec[wb_rd_addr] = 1'b1;
        if (kill_en && kill_addr != '0)   kill_vec[kill_addr] = 1'b1;
        if (set_en && set_addr != '0)     set_vec[set_addr]   = 1'b1;
    end

    // A register whose write lands this cycle is already visible through forwarding.
    assign busy_vec = pending & ~clr_vec;
    assign rs1_busy = busy_vec[rs1_addr];
    assign rs2_busy = busy_vec[rs2_addr];
    assign rd_busy  = busy_vec[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec & ~kill_vec) | set_vec;
        end
    end

endmodule

// File: rtl/armleocpu_operand_fetch.sv
// Operand fetch: issues register file reads, stalls on pending writes, forwards
// writeback data and keeps operands coherent while execute back-pressures.
module armleocpu_operand_fetch
    import armleocpu_operand_fetch_pkg::*;
#(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_rs1_used,
    input  logic [4:0]           in_rs1_addr,
    input  logic                 in_rs2_used,
    input  logic [4:0]           in_rs2_addr,
    input  logic                 in_rd_write,
    input  logic [4:0]           in_rd_addr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 rs1_read,
    output logic [4:0]           rs1_addr,
    input  logic [31:0]          rs1_rdata,
    output logic                 rs2_read,
    output logic [4:0]           rs2_addr,
    input  logic [31:0]          rs2_rdata,
    output logic                 rd_write,
    output logic [4:0]           rd_addr,
    output logic [31:0]          rd_wdata,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd_addr,
    input  logic [31:0]          wb_rd_wdata,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_rs1_data,
    output logic [31:0]          out_rs2_data,
    output logic                 out_rd_write,
    output logic [4:0]           out_rd_addr,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic     rs1_busy, rs2_busy, rd_busy;
    logic     hazard, issue, kill_en;
    logic     fresh_p1;
    logic     src1_used_p1, src2_used_p1;
    reg_idx_t src1_addr_p1, src2_addr_p1;
    logic     fwd1_flag_p1, fwd2_flag_p1;
    xlen_t    fwd1_data_p1, fwd2_data_p1;
    xlen_t    hold1_p1, hold2_p1;

    function automatic xlen_t select_operand(
        input logic used, input reg_idx_t addr, input logic fresh,
        input logic fwd_flag, input xlen_t fwd_data, input xlen_t rdata,
        input xlen_t hold, input logic wb_hit, input xlen_t wb_data);
        if (!used || addr == '0) return '0;
        if (!fresh)              return hold;
        if (wb_hit)              return wb_data;
        if (fwd_flag)            return fwd_data;
        return rdata;
    endfunction

    armleocpu_operand_fetch_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_rd_addr (wb_rd_addr),
        .set_en     (issue && in_rd_write),
        .set_addr   (in_rd_addr),
        .kill_en    (kill_en),
        .kill_addr  (out_rd_addr),
        .rs1_addr   (in_rs1_addr),
        .rs2_addr   (in_rs2_addr),
        .rd_addr    (in_rd_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_busy    (rd_busy)
    );

    assign hazard   = (in_rs1_used && rs1_busy) || (in_rs2_used && rs2_busy) ||
                      (in_rd_write && rd_busy);
    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign issue    = in_valid && in_ready;
    // out_rd_write is stale once the stage empties, so only a live instruction may release its bit.
    assign kill_en  = flush && out_valid && out_rd_write;

    assign rs1_read = issue && in_rs1_used;
    assign rs1_addr = in_rs1_addr;
    assign rs2_read = issue && in_rs2_used;
    assign rs2_addr = in_rs2_addr;

    assign rd_write = rst_n && wb_valid && (wb_rd_addr != '0);
    assign rd_addr  = wb_rd_addr;
    assign rd_wdata = wb_rd_wdata;

    assign out_rs1_data = select_operand(src1_used_p1, src1_addr_p1, fresh_p1, fwd1_flag_p1,
                              fwd1_data_p1, rs1_rdata, hold1_p1,
                              wb_hits(wb_valid, wb_rd_addr, src1_addr_p1), wb_rd_wdata);
    assign out_rs2_data = select_operand(src2_used_p1, src2_addr_p1, fresh_p1, fwd2_flag_p1,
                              fwd2_data_p1, rs2_rdata, hold2_p1,
                              wb_hits(wb_valid, wb_rd_addr, src2_addr_p1), wb_rd_wdata);

    // Stage p0 -> p1: capture issued instruction, or refresh hold copies while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            fresh_p1     <= 1'b0;
            src1_used_p1 <= 1'b0;
            src2_used_p1 <= 1'b0;
            src1_addr_p1 <= '0;
            src2_addr_p1 <= '0;
            fwd1_flag_p1 <= 1'b0;
            fwd2_flag_p1 <= 1'b0;
            fwd1_data_p1 <= '0;
            fwd2_data_p1 <= '0;
            hold1_p1     <= '0;
            hold2_p1     <= '0;
            out_rd_write <= 1'b0;
            out_rd_addr  <= '0;
            out_payload  <= '0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (issue)     out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            fresh_p1 <= issue;
            if (issue) begin
                src1_used_p1 <= in_rs1_used;
                src2_used_p1 <= in_rs2_used;
                src1_addr_p1 <= in_rs1_addr;
                src2_addr_p1 <= in_rs2_addr;
                fwd1_flag_p1 <= wb_hits(wb_valid, wb_rd_addr, in_rs1_addr);
                fwd2_flag_p1 <= wb_hits(wb_valid, wb_rd_addr, in_rs2_addr);
                fwd1_data_p1 <= wb_rd_wdata;
                fwd2_data_p1 <= wb_rd_wdata;
                out_rd_write <= in_rd_write;
                out_rd_addr  <= in_rd_addr;
                out_payload  <= in_payload;
            end else if (out_valid && !out_ready) begin
                hold1_p1 <= wb_hits(wb_valid, wb_rd_addr, src1_addr_p1) ? wb_rd_wdata : out_rs1_data;
                hold2_p1 <= wb_hits(wb_valid, wb_rd_addr, src2_addr_p1) ? wb_rd_wdata : out_rs2_data;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_operand_fetch.sv
// Bench for armleocpu_operand_fetch: directed scenarios plus randomized traffic
// compared each cycle against an architectural-state model of the stage.
module tb_armleocpu_operand_fetch;

    localparam int PAYLOAD_W = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_ready;
    logic                 in_rs1_used, in_rs2_used, in_rd_write;
    logic [4:0]           in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 rs1_read, rs2_read;
    logic [4:0]           rs1_addr, rs2_addr;
    logic [31:0]          rs1_rdata, rs2_rdata;
    logic                 rd_write;
    logic [4:0]           rd_addr;
    logic [31:0]          rd_wdata;
    logic                 wb_valid;
    logic [4:0]           wb_rd_addr;
    logic [31:0]          wb_rd_wdata;
    logic                 flush;
    logic                 out_valid, out_ready;
    logic [31:0]          out_rs1_data, out_rs2_data;
    logic                 out_rd_write;
    logic [4:0]           out_rd_addr;
    logic [PAYLOAD_W-1:0] out_payload;

    armleocpu_operand_fetch #(.PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_used(in_rs1_used), .in_rs1_addr(in_rs1_addr),
        .in_rs2_used(in_rs2_used), .in_rs2_addr(in_rs2_addr),
        .in_rd_write(in_rd_write), .in_rd_addr(in_rd_addr), .in_payload(in_payload),
        .rs1_read(rs1_read), .rs1_addr(rs1_addr), .rs1_rdata(rs1_rdata),
        .rs2_read(rs2_read), .rs2_addr(rs2_addr), .rs2_rdata(rs2_rdata),
        .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_write(out_rd_write), .out_rd_addr(out_rd_addr), .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 1) return 32'd5;
        if (i == 2) return 32'd7;
        return 32'h1000_0000 + i;
    endfunction

    // Environment register file: synchronous read returning pre-write data.
    logic [31:0] rf [32];
    bit          rf_init = 1'b0;
    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
            rf_init <= 1'b1;
        end else begin
            if (rd_write) rf[rd_addr] <= rd_wdata;
            if (rs1_read) rs1_rdata <= rf[rs1_addr];
            if (rs2_read) rs2_rdata <= rf[rs2_addr];
        end
    end

    // Architectural model: register values, pending writes, and the stage contents.
    logic [31:0]          m_regs [32];
    bit                   m_pending [32];
    bit                   m_init = 1'b0;
    bit                   m_valid, m_fresh;
    bit                   m_rs1_used, m_rs2_used, m_rdw;
    logic [4:0]           m_rs1, m_rs2, m_rd;
    logic [PAYLOAD_W-1:0] m_payload;

    int n_cmp = 0;
    int n_fail = 0;
    int lit_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && m_pending[r] && !(wb_valid && wb_rd_addr == r);
    endfunction

    function automatic logic [31:0] exp_op(input bit used, input logic [4:0] r);
        if (!used || r == 0) return 32'd0;
        if (m_fresh && wb_valid && wb_rd_addr == r) return wb_rd_wdata;
        return m_regs[r];
    endfunction

    always @(negedge clk) begin
        bit er, iss;
        if (!rst_n) begin
            if (!m_init) begin
                for (int i = 0; i < 32; i++) m_regs[i] = init_val(i);
                m_init = 1'b1;
            end
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_rd_write", {63'd0, rd_write}, 64'd0);
            m_valid = 1'b0;
            m_fresh = 1'b0;
            for (int i = 0; i < 32; i++) m_pending[i] = 1'b0;
        end else begin
            er = !((in_rs1_used && m_busy(in_rs1_addr)) || (in_rs2_used && m_busy(in_rs2_addr)) ||
                   (in_rd_write && m_busy(in_rd_addr))) && (!m_valid || out_ready) && !flush;
            iss = in_valid && er;
            check("in_ready", {63'd0, in_ready}, {63'd0, er});
            check("rd_write", {63'd0, rd_write}, {63'd0, wb_valid && wb_rd_addr != 0});
            if (wb_valid) begin
                check("rd_addr", {59'd0, rd_addr}, {59'd0, wb_rd_addr});
                check("rd_wdata", {32'd0, rd_wdata}, {32'd0, wb_rd_wdata});
            end
            check("rs1_read", {63'd0, rs1_read}, {63'd0, iss && in_rs1_used});
            check("rs2_read", {63'd0, rs2_read}, {63'd0, iss && in_rs2_used});
            if (iss && in_rs1_used) check("rs1_addr", {59'd0, rs1_addr}, {59'd0, in_rs1_addr});
            if (iss && in_rs2_used) check("rs2_addr", {59'd0, rs2_addr}, {59'd0, in_rs2_addr});
            check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            if (m_valid) begin
                check("out_rs1_data", {32'd0, out_rs1_data}, {32'd0, exp_op(m_rs1_used, m_rs1)});
                check("out_rs2_data", {32'd0, out_rs2_data}, {32'd0, exp_op(m_rs2_used, m_rs2)});
                check("out_rd_write", {63'd0, out_rd_write}, {63'd0, m_rdw});
                check("out_rd_addr", {59'd0, out_rd_addr}, {59'd0, m_rd});
                check("out_payload", out_payload, m_payload);
            end
            case (lit_id)
                1: begin
                    check("lit_reset_valid", {63'd0, out_valid}, 64'd0);
                    check("lit_reset_payload", out_payload, 64'd0);
                    check("lit_reset_ready", {63'd0, in_ready}, 64'd1);
                end
                2: check("lit_b2b_ready0", {63'd0, in_ready}, 64'd1);
                3: begin
                    check("lit_b2b_ready1", {63'd0, in_ready}, 64'd1);
                    check("lit_b2b_a_rs1", {32'd0, out_rs1_data}, 64'd5);
                    check("lit_b2b_a_rs2", {32'd0, out_rs2_data}, 64'd7);
                end
                4: begin
                    check("lit_b2b_b_valid", {63'd0, out_valid}, 64'd1);
                    check("lit_b2b_b_rs1", {32'd0, out_rs1_data}, 64'd5);
                    check("lit_b2b_b_rs2", {32'd0, out_rs2_data}, 64'd5);
                end
                5: check("lit_raw_stall", {63'd0, in_ready}, 64'd0);
                6: check("lit_raw_release", {63'd0, in_ready}, 64'd1);
                7: check("lit_raw_fwd", {32'd0, out_rs1_data}, 64'hDEAD);
                8: check("lit_bp_c1", {32'd0, out_rs1_data}, 64'h1000_0006);
                9: check("lit_bp_c2", {32'd0, out_rs1_data}, 64'h1000_0006);
                10: check("lit_bp_c3", {32'd0, out_rs1_data}, 64'h1234);
                11: begin
                    check("lit_bp_c4", {32'd0, out_rs1_data}, 64'h1234);
                    check("lit_bp_c4_valid", {63'd0, out_valid}, 64'd1);
                end
                12: begin
                    check("lit_x0_ready", {63'd0, in_ready}, 64'd1);
                    check("lit_x0_rd_write", {63'd0, rd_write}, 64'd0);
                end
                13: begin
                    check("lit_x0_rs1", {32'd0, out_rs1_data}, 64'd0);
                    check("lit_x0_rs2", {32'd0, out_rs2_data}, 64'd5);
                end
                14: check("lit_flush_ready", {63'd0, in_ready}, 64'd0);
                15: begin
                    check("lit_flush_valid", {63'd0, out_valid}, 64'd0);
                    check("lit_flush_nostall", {63'd0, in_ready}, 64'd1);
                end
                17: check("lit_reset_nostall", {63'd0, in_ready}, 64'd1);
                default: ;
            endcase
            // Advance the model across the coming clock edge.
            if (wb_valid && wb_rd_addr != 0) begin
                m_pending[wb_rd_addr] = 1'b0;
                m_regs[wb_rd_addr] = wb_rd_wdata;
            end
            if (flush && m_valid && m_rdw && m_rd != 0) m_pending[m_rd] = 1'b0;
            if (iss && in_rd_write && in_rd_addr != 0) m_pending[in_rd_addr] = 1'b1;
            if (flush)          m_valid = 1'b0;
            else if (iss)       m_valid = 1'b1;
            else if (out_ready) m_valid = 1'b0;
            m_fresh = iss;
            if (iss) begin
                m_rs1_used = in_rs1_used; m_rs1 = in_rs1_addr;
                m_rs2_used = in_rs2_used; m_rs2 = in_rs2_addr;
                m_rdw = in_rd_write;      m_rd = in_rd_addr;
                m_payload = in_payload;
            end
        end
    end

    task automatic step(input int lit);
        @(posedge clk);
        #1;
        in_valid = 0; in_rs1_used = 0; in_rs2_used = 0; in_rd_write = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_payload = {$urandom, $urandom};
        wb_valid = 0; wb_rd_addr = 0; wb_rd_wdata = 0;
        flush = 0; out_ready = 1;
        lit_id = lit;
    endtask

    task automatic instr(input bit u1, input logic [4:0] a1, input bit u2, input logic [4:0] a2,
                         input bit w, input logic [4:0] d);
        in_valid = 1;
        in_rs1_used = u1; in_rs1_addr = a1;
        in_rs2_used = u2; in_rs2_addr = a2;
        in_rd_write = w;  in_rd_addr = d;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1; wb_rd_addr = a; wb_rd_wdata = d;
    endtask

    initial begin
        rst_n = 0;
        in_valid = 0; in_rs1_used = 0; in_rs2_used = 0; in_rd_write = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_payload = 0;
        wb_valid = 0; wb_rd_addr = 0; wb_rd_wdata = 0; flush = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1; lit_id = 1;

        step(2);  instr(1, 1, 1, 2, 1, 3);
        step(3);  instr(1, 1, 1, 1, 1, 4);
        step(4);
        step(0);  instr(0, 0, 0, 0, 1, 5);
        step(5);  instr(1, 5, 0, 0, 1, 5);
        step(6);  instr(1, 5, 0, 0, 1, 5); wb(5, 32'hDEAD);
        step(7);
        step(0);  wb(5, 32'h55);
        step(0);  instr(1, 6, 0, 0, 0, 0);
        step(8);  out_ready = 0;
        step(9);  out_ready = 0; wb(6, 32'h1234);
        step(10); out_ready = 0;
        step(11);
        step(12); instr(1, 0, 1, 1, 1, 0); wb(0, 32'hFFFF);
        step(13);
        step(0);  instr(0, 0, 0, 0, 1, 9);
        step(14); out_ready = 0; flush = 1;
        step(15); instr(1, 9, 0, 0, 0, 0);
        step(0);
        step(0);  instr(0, 0, 0, 0, 1, 3);
        step(0);  out_ready = 0;
        step(0);  rst_n = 0; out_ready = 0; wb(3, 32'h3333);
        step(0);  rst_n = 0;
        step(17); rst_n = 1; instr(1, 3, 0, 0, 1, 3);
        step(0);

        for (int c = 0; c < 3000; c++) begin
            step(0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 7)
                instr($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
                      5'($urandom_range(0, 7)), $urandom_range(0, 1), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 4) begin
                int start;
                int pick;
                start = $urandom_range(0, 31);
                pick = $urandom_range(0, 31);
                if ($urandom_range(0, 9) < 7)
                    for (int k = 0; k < 32; k++)
                        if (m_pending[(start + k) % 32]) begin
                            pick = (start + k) % 32;
                            break;
                        end
                wb(5'(pick), $urandom);
            end
            if (m_valid && $urandom_range(0, 19) == 0) flush = 1;
        end
        step(0);
        step(0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
